// File: rtl/mgmt_spi_slave_pkg.sv
// Shared types and helpers for the management SPI slave.
package mgmt_spi_slave_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Byte presented on MISO at a byte boundary: the pending reply, else the fill pattern.
    function automatic logic [BYTE_W-1:0] next_tx_byte(
        input logic              pending,
        input logic [BYTE_W-1:0] hold,
        input logic [BYTE_W-1:0] fill
    );
        return pending ? hold : fill;
    endfunction

endpackage

// File: rtl/mgmt_spi_slave_pin_sync.sv
// N-flop input synchroniser with edge detection against one extra registered copy.
module spi_pin_sync #(
    parameter int unsigned N         = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [N-1:0] sync_q, sync_d;
    logic         prev_q, prev_d;

    // Shift the pin through the chain; keep one delayed copy of the last stage.
    always_comb begin
        sync_d = {sync_q[N-2:0], pin};
        prev_d = sync_q[N-1];
    end

    // Synchroniser and edge-history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {N{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[N-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/mgmt_spi_slave.sv
// Oversampled mode-0 SPI slave: byte deserialiser, reply serialiser and CS# framing strobe.
module mgmt_spi_slave
    import mgmt_spi_slave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_FILL   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n_pin,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       spi_rx_data_valid,
    output logic [7:0] spi_rx_data,
    output logic       spi_cs_falling,
    output logic       spi_cs_n,
    input  logic       spi_tx_data_valid,
    input  logic [7:0] spi_tx_data,
    output logic       spi_tx_overrun
);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_pin_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .pin(spi_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    spi_pin_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .pin(spi_cs_n_pin),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .pin(spi_mosi),
        .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_edges = ^{sck_lvl, mosi_rise, mosi_fall};

    spi_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        pending_q, pending_d;
    logic        cs_fall_q, cs_fall_d;
    logic        overrun_q, overrun_d;
    logic        consume;

    // Framing, bit counting, shift registers and reply holding register.
    always_comb begin
        // NOTE: every value gets a default first, so no path can leave a latch behind.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        hold_d     = hold_q;
        pending_d  = pending_q;
        cs_fall_d  = 1'b0;
        overrun_d  = 1'b0;
        consume    = 1'b0;

        if (cs_fall) begin
            state_d    = ST_ACTIVE;
            cnt_d      = 3'd0;
            tx_shift_d = next_tx_byte(pending_q, hold_q, IDLE_FILL);
            consume    = pending_q;
            cs_fall_d  = 1'b1;
        end else if (cs_rise) begin
            // A partial byte is simply abandoned; the rx shifter is overwritten next frame.
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else if (state_q == ST_ACTIVE) begin
            if (sck_rise) begin
                rx_shift_d = {rx_shift_q[5:0], mosi_lvl};
                cnt_d      = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    rx_data_d  = {rx_shift_q, mosi_lvl};
                    rx_valid_d = 1'b1;
                end
            end else if (sck_fall) begin
                if (cnt_q == 3'd0) begin
                    tx_shift_d = next_tx_byte(pending_q, hold_q, IDLE_FILL);
                    consume    = pending_q;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end

        if (consume || cs_rise) begin
            pending_d = 1'b0;
        end

        // A load in the same cycle as a reload stays pending for the next byte.
        if (spi_tx_data_valid) begin
            hold_d    = spi_tx_data;
            pending_d = 1'b1;
            overrun_d = pending_q & ~consume;
        end
    end

    // Register all datapath and control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            rx_shift_q <= 7'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_shift_q <= IDLE_FILL;
            // NOTE: the holding register resets to the fill byte so an early reload is defined.
            hold_q     <= IDLE_FILL;
            pending_q  <= 1'b0;
            cs_fall_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_shift_q <= tx_shift_d;
            hold_q     <= hold_d;
            pending_q  <= pending_d;
            cs_fall_q  <= cs_fall_d;
            overrun_q  <= overrun_d;
        end
    end

    assign spi_miso          = tx_shift_q[7];
    assign spi_miso_oe       = ~cs_lvl;
    assign spi_cs_n          = cs_lvl;
    assign spi_rx_data_valid = rx_valid_q;
    assign spi_rx_data       = rx_data_q;
    assign spi_cs_falling    = cs_fall_q;
    assign spi_tx_overrun    = overrun_q;

endmodule
